// File: rtl/lampfpu_addsub_arbiter.sv
// rtl/lampfpu_addsub_arbiter.sv - round-robin share of one bf16 add/sub unit with tag pipe and credited response FIFO
module lampfpu_addsub_arbiter #(
  parameter int N_REQ     = 4,
  parameter int LAT       = 2,
  parameter int RSP_DEPTH = 4,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [N_REQ*16-1:0] req_op1_i,
  input  logic [N_REQ*16-1:0] req_op2_i,
  input  logic [N_REQ-1:0]    req_isSub_i,
  output logic                fu_doAddSub_o,
  output logic                fu_isOpSub_o,
  output logic [15:0]         fu_op1_o,
  output logic [15:0]         fu_op2_o,
  input  logic                fu_valid_i,
  input  logic [15:0]         fu_res_i,
  input  logic [1:0]          fu_flags_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [ID_W-1:0]     rsp_id_o,
  output logic [15:0]         rsp_res_o,
  output logic [1:0]          rsp_flags_o,
  output logic                err_o
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int EW = ID_W + 18;

  logic [ID_W-1:0] rrPtr;
  logic [ID_W-1:0] grantId;
  logic [ID_W-1:0] scanIdx;
  logic [ID_W-1:0] fuId;
  logic [CW-1:0]   cnt;
  logic            found;
  logic            canIssue;
  logic            handshake;

  // Rotating priority search starting at rrPtr.
  always_comb begin
    found   = 1'b0;
    grantId = '0;
    scanIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scanIdx = ID_W'((int'(rrPtr) + i) % N_REQ);
      if (!found && req_valid_i[scanIdx]) begin
        found   = 1'b1;
        grantId = scanIdx;
      end
    end
  end

  assign canIssue    = (cnt < CW'(RSP_DEPTH));
  assign handshake   = canIssue & found;
  assign req_ready_o = handshake ? (N_REQ'(1) << grantId) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fu_doAddSub_o <= 1'b0;
      fu_isOpSub_o  <= 1'b0;
      fu_op1_o      <= '0;
      fu_op2_o      <= '0;
      fuId          <= '0;
      rrPtr         <= '0;
    end else if (handshake) begin
      fu_doAddSub_o <= 1'b1;
      fu_isOpSub_o  <= req_isSub_i[grantId];
      fu_op1_o      <= req_op1_i[{grantId, 4'b0000} +: 16];
      fu_op2_o      <= req_op2_i[{grantId, 4'b0000} +: 16];
      fuId          <= grantId;
      rrPtr         <= (grantId == ID_W'(N_REQ - 1)) ? '0 : grantId + ID_W'(1);
    end else begin
      fu_doAddSub_o <= 1'b0;
    end
  end

  logic [LAT-1:0]  tagValid;
  logic [ID_W-1:0] tagId [LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tagValid <= '0;
      for (int i = 0; i < LAT; i++) tagId[i] <= '0;
    end else begin
      tagValid[0] <= fu_doAddSub_o;
      tagId[0]    <= fuId;
      for (int i = 1; i < LAT; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagId[i]    <= tagId[i-1];
      end
    end
  end

  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;
  logic [EW-1:0] mem [RSP_DEPTH];
  logic          empty;
  logic          full;
  logic          tagOut;
  logic          push;
  logic          pop;
  logic          protoErr;

  assign empty    = (wrPtr == rdPtr);
  assign full     = ((wrPtr ^ rdPtr) == {1'b1, {AW{1'b0}}});
  assign tagOut   = tagValid[LAT-1];
  assign push     = fu_valid_i & tagOut & ~full;
  assign pop      = ~empty & rsp_ready_i;
  // A result without a tag, a tag without a result, or an overfull push all flag the protocol.
  assign protoErr = (fu_valid_i ^ tagOut) | (fu_valid_i & tagOut & full);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
      err_o <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wrPtr[AW-1:0]] <= {tagId[LAT-1], fu_res_i, fu_flags_i};
        wrPtr              <= wrPtr + (AW+1)'(1);
      end
      if (pop) rdPtr <= rdPtr + (AW+1)'(1);
      if (protoErr) err_o <= 1'b1;
      case ({handshake, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rsp_valid_o = ~empty;
  assign {rsp_id_o, rsp_res_o, rsp_flags_o} = empty ? '0 : mem[rdPtr[AW-1:0]];

endmodule

// File: tb/tb_lampfpu_addsub_arbiter.sv
// tb/tb_lampfpu_addsub_arbiter.sv - cycle-level queue model bench with emulated add/sub unit for lampfpu_addsub_arbiter
module tb_lampfpu_addsub_arbiter;
  localparam int N_REQ     = 4;
  localparam int LAT       = 2;
  localparam int RSP_DEPTH = 4;
  localparam int ID_W      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstN;
  logic [N_REQ-1:0]    reqValid;
  logic [N_REQ-1:0]    reqSub;
  logic [N_REQ*16-1:0] reqOp1;
  logic [N_REQ*16-1:0] reqOp2;
  logic                rspReady;
  logic                fuValid;
  logic [15:0]         fuRes;
  logic [1:0]          fuFlags;

  logic [N_REQ-1:0]    reqReady;
  logic                fuDo;
  logic                fuSub;
  logic [15:0]         fuOp1;
  logic [15:0]         fuOp2;
  logic                rspValid;
  logic [ID_W-1:0]     rspId;
  logic [15:0]         rspRes;
  logic [1:0]          rspFlags;
  logic                err;

  lampfpu_addsub_arbiter #(.N_REQ(N_REQ), .LAT(LAT), .RSP_DEPTH(RSP_DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rstN),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_op1_i(reqOp1), .req_op2_i(reqOp2),
    .req_isSub_i(reqSub),
    .fu_doAddSub_o(fuDo), .fu_isOpSub_o(fuSub), .fu_op1_o(fuOp1), .fu_op2_o(fuOp2),
    .fu_valid_i(fuValid), .fu_res_i(fuRes), .fu_flags_i(fuFlags),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_id_o(rspId), .rsp_res_o(rspRes),
    .rsp_flags_o(rspFlags), .err_o(err)
  );

  typedef struct {int id; int due;} tagEnt;
  typedef struct {int due; logic [15:0] res; logic [1:0] flags;} fuEnt;
  typedef struct {int id; logic [15:0] res; logic [1:0] flags;} rspEnt;

  // Reference model state: queues of outstanding ops and pending responses.
  int          mRr, mCnt;
  bit          mDo, mSub, mErr;
  logic [15:0] mOp1, mOp2;
  tagEnt       tagQ[$];
  rspEnt       rspQ[$];
  fuEnt        fuSched[$];
  int          orderQ[$];

  int  cyc, nChecks, nFails;
  bit  checkOn, strayFu;

  logic [3:0]  obsReady;
  logic        obsDo, obsSub, obsRspValid, obsErr;
  logic [15:0] obsOp1, obsOp2, obsRes;
  logic [1:0]  obsFlags;
  logic [1:0]  obsId;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic int firstSet(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Stand-in for the arithmetic unit: real bf16 results for the pinned cases, a fixed scramble otherwise.
  function automatic logic [17:0] fuCalc(logic [15:0] a, logic [15:0] b, logic s);
    if (a == 16'h3F80 && b == 16'h4000 && !s) return {2'b00, 16'h4040};
    if (a == 16'h4040 && b == 16'h3F80 && s)  return {2'b00, 16'h4000};
    return {a[0] ^ b[1], b[0], a ^ {b[7:0], b[15:8]} ^ (s ? 16'h8000 : 16'h0000)};
  endfunction

  task automatic setReq(int k, logic [15:0] a, logic [15:0] b, logic s);
    reqOp1[16*k +: 16] = a;
    reqOp2[16*k +: 16] = b;
    reqSub[k] = s;
  endtask

  task automatic tick();
    int g;
    logic [3:0] expReady;
    bit hs, tagHit, doPop, pushIt;
    fuEnt fe;
    tagEnt te;
    rspEnt re, pe;
    logic [17:0] r;
    fuValid = 1'b0; fuRes = '0; fuFlags = '0;
    if (fuSched.size() > 0 && fuSched[0].due == cyc) begin
      fe = fuSched.pop_front();
      fuValid = 1'b1; fuRes = fe.res; fuFlags = fe.flags;
    end
    if (strayFu) begin fuValid = 1'b1; fuRes = 16'hBEEF; fuFlags = 2'b11; end
    #1;
    g = -1;
    if (mCnt < RSP_DEPTH)
      for (int k = 0; k < N_REQ; k++)
        if (g < 0 && reqValid[(mRr + k) % N_REQ]) g = (mRr + k) % N_REQ;
    expReady = (g >= 0) ? 4'(1 << g) : 4'b0000;
    hs = rstN && (g >= 0);
    obsReady = reqReady; obsDo = fuDo; obsSub = fuSub; obsOp1 = fuOp1; obsOp2 = fuOp2;
    obsRspValid = rspValid; obsId = rspId; obsRes = rspRes; obsFlags = rspFlags; obsErr = err;
    if (checkOn) begin
      chk("req_ready", reqReady, expReady);
      chk("fu_do", fuDo, mDo);
      chk("fu_op1", fuOp1, mOp1);
      chk("fu_op2", fuOp2, mOp2);
      chk("fu_sub", fuSub, mSub);
      chk("rsp_valid", rspValid, rspQ.size() > 0);
      if (rspQ.size() > 0) begin
        chk("rsp_id", rspId, rspQ[0].id);
        chk("rsp_res", rspRes, rspQ[0].res);
        chk("rsp_flags", rspFlags, rspQ[0].flags);
      end
      chk("err", err, mErr);
      if (!rstN) orderQ.delete();
      else begin
        if (reqReady != 0) orderQ.push_back(firstSet(reqReady));
        if (rspValid && rspReady) begin
          if (orderQ.size() > 0) chk("issue_order", rspId, orderQ.pop_front());
          else chk("issue_order_extra", orderQ.size(), 1);
        end
      end
    end
    if (fuDo === 1'b1) begin
      r = fuCalc(fuOp1, fuOp2, fuSub);
      fuSched.push_back('{cyc + LAT, r[15:0], r[17:16]});
    end
    if (!rstN) begin
      mRr = 0; mCnt = 0; mDo = 0; mSub = 0; mOp1 = 0; mOp2 = 0; mErr = 0;
      tagQ.delete(); rspQ.delete();
    end else begin
      tagHit = tagQ.size() > 0 && tagQ[0].due == cyc;
      doPop  = rspQ.size() > 0 && rspReady;
      pushIt = 0;
      if (fuValid != tagHit) mErr = 1;
      if (tagHit) begin
        te = tagQ.pop_front();
        if (fuValid) begin
          if (rspQ.size() >= RSP_DEPTH) mErr = 1;
          else begin pushIt = 1; pe = '{te.id, fuRes, fuFlags}; end
        end
      end
      if (doPop) begin re = rspQ.pop_front(); mCnt--; end
      if (pushIt) rspQ.push_back(pe);
      if (hs) begin
        mCnt++;
        mRr  = (g + 1) % N_REQ;
        mDo  = 1;
        mOp1 = reqOp1[16*g +: 16];
        mOp2 = reqOp2[16*g +: 16];
        mSub = reqSub[g];
        tagQ.push_back('{g, cyc + 1 + LAT});
      end else mDo = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic waitRsp(string name);
    int n = 0;
    do begin tick(); n++; end while (!obsRspValid && n < 20);
    chk(name, obsRspValid, 1'b1);
  endtask

  int n, k, hsCount;

  initial begin
    rstN = 0; reqValid = 0; reqSub = 0; reqOp1 = 0; reqOp2 = 0; rspReady = 0;
    fuValid = 0; fuRes = 0; fuFlags = 0;
    strayFu = 0; checkOn = 0; cyc = 0; nChecks = 0; nFails = 0;
    @(posedge clk); #1;
    tick(); tick();
    rstN = 1; checkOn = 1;
    tick();
    chk("reset_ready", obsReady, 4'b0000);
    chk("reset_do", obsDo, 1'b0);
    chk("reset_rsp_valid", obsRspValid, 1'b0);
    chk("reset_rsp_res", obsRes, 16'h0000);
    chk("reset_err", obsErr, 1'b0);

    // single add from requester 0
    setReq(0, 16'h3F80, 16'h4000, 1'b0); reqValid = 4'b0001; rspReady = 1;
    tick();
    chk("t1_grant", obsReady, 4'b0001);
    reqValid = 0;
    tick();
    chk("t1_do", obsDo, 1'b1);
    chk("t1_op1", obsOp1, 16'h3F80);
    chk("t1_op2", obsOp2, 16'h4000);
    chk("t1_sub", obsSub, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!obsRspValid && n < 20);
    chk("t1_latency", n, 3);
    chk("t1_rsp_id", obsId, 2'd0);
    chk("t1_rsp_res", obsRes, 16'h4040);
    chk("t1_rsp_flags", obsFlags, 2'b00);

    // fairness with every requester valid
    for (int i = 0; i < N_REQ; i++) setReq(i, 16'($urandom), 16'($urandom), 1'($urandom));
    reqValid = 4'b1111; k = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (t < 4) chk("t2_no_gap", obsReady != 0, 1'b1);
      if (obsReady != 0) begin chk("t2_rr_order", firstSet(obsReady), (1 + k) % 4); k++; end
    end
    reqValid = 0;
    repeat (10) tick();

    // backpressure: credits stop issue at RSP_DEPTH
    rspReady = 0; reqValid = 4'b0001; hsCount = 0;
    repeat (12) begin tick(); if (obsReady != 0) hsCount++; end
    chk("t3_handshakes", hsCount, 4);
    chk("t3_ready_low", obsReady, 4'b0000);
    rspReady = 1; tick();
    chk("t3_pop_valid", obsRspValid, 1'b1);
    rspReady = 0; hsCount = 0;
    repeat (6) begin tick(); if (obsReady != 0) hsCount++; end
    chk("t3_one_more", hsCount, 1);

    // full FIFO drained while new ops push behind it
    reqValid = 4'b1111; rspReady = 1;
    tick();
    chk("t4_stall_at_full", obsReady, 4'b0000);
    repeat (20) tick();
    reqValid = 0;
    repeat (10) tick();

    // reset with ops in flight; the unit's late results become stray
    reqValid = 4'b1111; tick(); tick();
    reqValid = 0; rstN = 0; tick();
    rstN = 1; tick();
    chk("t5_do", obsDo, 1'b0);
    chk("t5_rsp_valid", obsRspValid, 1'b0);
    chk("t5_err_clear", obsErr, 1'b0);
    chk("t5_op1", obsOp1, 16'h0000);
    repeat (3) tick();
    chk("t5_err_sticky", obsErr, 1'b1);
    chk("t5_no_rsp", obsRspValid, 1'b0);
    rstN = 0; tick(); rstN = 1; tick();

    // subtract from requester 2, twice, to walk rr_ptr to 3
    setReq(2, 16'h4040, 16'h3F80, 1'b1); reqValid = 4'b0100;
    tick();
    chk("t6_grant_a", obsReady, 4'b0100);
    reqValid = 0;
    waitRsp("t6_rsp_a_timeout");
    chk("t6_rsp_a_id", obsId, 2'd2);
    chk("t6_rsp_a_res", obsRes, 16'h4000);
    reqValid = 4'b0100;
    tick();
    chk("t6_grant_b", obsReady, 4'b0100);
    reqValid = 0;
    waitRsp("t6_rsp_b_timeout");
    chk("t6_rsp_b_id", obsId, 2'd2);
    chk("t6_rsp_b_res", obsRes, 16'h4000);
    chk("t6_rsp_b_flags", obsFlags, 2'b00);
    reqValid = 4'b1111;
    tick();
    chk("t6_rr_at_3", obsReady, 4'b1000);
    reqValid = 0;
    repeat (10) tick();

    // randomized traffic
    for (int t = 0; t < 2000; t++) begin
      reqValid = 4'($urandom);
      reqSub   = 4'($urandom);
      reqOp1   = {$urandom, $urandom};
      reqOp2   = {$urandom, $urandom};
      rspReady = (t % 200 < 150) ? (($urandom % 4) != 0) : (($urandom % 8) == 0);
      tick();
    end
    reqValid = 0; rspReady = 1;
    repeat (12) tick();
    chk("final_err", obsErr, 1'b0);
    chk("final_empty", obsRspValid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
